// File: rtl/encoder_pkg.sv
// Shared encoder definitions: scheduler state encoding and the default file-index width.
package encoder_pkg;

    localparam int unsigned FILE_W_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FIN    = 3'd4
    } sched_state_e;

endpackage

// File: rtl/rev_watchdog.sv
// Per-run watchdog: cleared before a run, counts while running, flags expiry when the count
// is about to reach TMO-1.
module rev_watchdog #(
    parameter int unsigned TMO   = 4096,
    parameter int unsigned TMO_W = 13
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    logic [TMO_W-1:0] r_count;
    logic [TMO_W-1:0] w_count_inc;

    assign w_count_inc = r_count + TMO_W'(1);
    assign o_expire    = i_run && (w_count_inc == TMO_W'(TMO - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/revaluate_sched.sv
// Batch scheduler: runs revaluate over a wrapping range of file indices one file at a time,
// supervising each run with a watchdog and counting completed files.
module revaluate_sched
    import encoder_pkg::*;
#(
    parameter int unsigned FILE_W = FILE_W_DEF,
    parameter int unsigned TMO    = 4096,
    parameter int unsigned TMO_W  = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go,
    input  logic [FILE_W-1:0] i_first_idx,
    input  logic [FILE_W-1:0] i_last_idx,
    input  logic              i_abort,
    output logic              o_rev_start,
    input  logic              i_rev_finish,
    output logic [FILE_W-1:0] o_file_index,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [FILE_W:0]   o_files_done
);

    sched_state_e      r_state, w_state_d;
    logic              r_go;
    logic [FILE_W-1:0] r_go_first;
    logic [FILE_W-1:0] r_go_last;
    logic [FILE_W-1:0] r_last, w_last_d;
    logic              r_rev_start, w_rev_start_d;
    logic [FILE_W-1:0] r_file_index, w_file_index_d;
    logic              r_busy, w_busy_d;
    logic              r_done, w_done_d;
    logic              r_error, w_error_d;
    logic [FILE_W:0]   r_files_done, w_files_done_d;
    logic              w_wd_clear;
    logic              w_wd_run;
    logic              w_expire;

    assign w_wd_clear = (r_state == S_LAUNCH);
    assign w_wd_run   = (r_state == S_WAIT);

    rev_watchdog #(
        .TMO   (TMO),
        .TMO_W (TMO_W)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_wd_clear),
        .i_run    (w_wd_run),
        .o_expire (w_expire)
    );

    // The request and its range are registered once: launch lands two cycles after go, and a
    // go raised in the done cycle (busy already low) is still seen in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_go       <= 1'b0;
            r_go_first <= '0;
            r_go_last  <= '0;
        end else begin
            r_go       <= i_go;
            r_go_first <= i_first_idx;
            r_go_last  <= i_last_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_last       <= '0;
            r_rev_start  <= 1'b0;
            r_file_index <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_files_done <= '0;
        end else begin
            r_state      <= w_state_d;
            r_last       <= w_last_d;
            r_rev_start  <= w_rev_start_d;
            r_file_index <= w_file_index_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_error      <= w_error_d;
            r_files_done <= w_files_done_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_last_d       = r_last;
        w_rev_start_d  = 1'b0;
        w_file_index_d = r_file_index;
        w_busy_d       = r_busy;
        w_done_d       = 1'b0;
        w_error_d      = r_error;
        w_files_done_d = r_files_done;
        unique case (r_state)
            S_IDLE: begin
                if (r_go) begin
                    w_state_d      = S_LAUNCH;
                    w_last_d       = r_go_last;
                    w_file_index_d = r_go_first;
                    w_files_done_d = '0;
                    w_error_d      = 1'b0;
                    w_busy_d       = 1'b1;
                    w_rev_start_d  = 1'b1;
                end
            end
            S_LAUNCH: begin
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                // A finish in the expiry cycle still counts as a completed file.
                if (i_rev_finish) begin
                    w_files_done_d = r_files_done + (FILE_W + 1)'(1);
                    w_state_d      = S_NEXT;
                end else if (w_expire) begin
                    w_error_d = 1'b1;
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = S_FIN;
                end
            end
            S_NEXT: begin
                if ((r_file_index == r_last) || i_abort) begin
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = S_FIN;
                end else begin
                    w_file_index_d = r_file_index + FILE_W'(1);
                    w_rev_start_d  = 1'b1;
                    w_state_d      = S_LAUNCH;
                end
            end
            S_FIN: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign o_rev_start  = r_rev_start;
    assign o_file_index = r_file_index;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_files_done = r_files_done;

endmodule

// File: tb/tb_revaluate_sched.sv
// Bench for revaluate_sched: revaluate is modelled as "finish N cycles after start"; a
// timestamp-based expectation model is checked every cycle, plus literal expectations.
module tb_revaluate_sched;

    localparam int FW  = 10;
    localparam int TMO = 16;

    logic          clk;
    logic          rst_n;
    logic          go;
    logic [FW-1:0] first_idx;
    logic [FW-1:0] last_idx;
    logic          abort;
    logic          rev_start;
    logic          rev_finish;
    logic [FW-1:0] file_index;
    logic          busy;
    logic          done;
    logic          error;
    logic [FW:0]   files_done;

    revaluate_sched #(
        .FILE_W (FW),
        .TMO    (TMO),
        .TMO_W  (5)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_go         (go),
        .i_first_idx  (first_idx),
        .i_last_idx   (last_idx),
        .i_abort      (abort),
        .o_rev_start  (rev_start),
        .i_rev_finish (rev_finish),
        .o_file_index (file_index),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_files_done (files_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int rv_lat    = 10;  // 0 means revaluate never finishes
    int rv_cnt    = 0;
    bit rv_seen   = 1'b0;
    bit stray_fin = 1'b0;

    int log_idx[$];
    int log_cyc[$];
    int exp_seq[$];
    int done_cnt      = 0;
    int last_done_cyc = 0;
    int last_fin_cyc  = 0;
    int err_rise_cyc  = 0;
    bit prev_err      = 1'b0;
    int go_cyc        = 0;

    // Expected outputs for the current cycle and the scheduling state behind them.
    logic          e_start, e_busy, e_done, e_err;
    logic [FW-1:0] e_idx;
    logic [FW:0]   e_fd;
    logic          n_start, n_busy, n_done, n_err;
    logic [FW-1:0] n_idx;
    logic [FW:0]   n_fd;
    bit            m_engaged, m_running;
    logic [FW-1:0] m_cur, m_last;
    int            m_launch_at, m_decide_at, m_done_cyc, m_start_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Revaluate stand-in: a start seen in cycle L gives a finish pulse in cycle L+rv_lat.
    initial begin
        rev_finish = 1'b0;
        forever begin
            @(negedge clk);
            rv_seen = rev_start;
            @(posedge clk);
            #1;
            rev_finish = 1'b0;
            if (rv_seen && rv_lat > 0) rv_cnt = rv_lat;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) rev_finish = 1'b1;
            end
            if (stray_fin) begin
                rev_finish = 1'b1;
                stray_fin  = 1'b0;
            end
        end
    end

    // Compare, then advance the model to the next cycle's expectations.
    initial begin
        e_start = 0; e_busy = 0; e_done = 0; e_err = 0; e_idx = '0; e_fd = '0;
        m_engaged = 0; m_running = 0; m_cur = '0; m_last = '0;
        m_launch_at = -1; m_decide_at = -1; m_done_cyc = -10; m_start_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_start = 0; e_busy = 0; e_done = 0; e_err = 0; e_idx = '0; e_fd = '0;
                m_engaged = 0; m_running = 0;
                m_launch_at = -1; m_decide_at = -1; m_done_cyc = -10;
            end
            n_checks++;
            if (rev_start !== e_start || file_index !== e_idx || busy !== e_busy ||
                done !== e_done || error !== e_err || files_done !== e_fd) begin
                n_errors++;
                $display("FAIL cycle %0d outputs: got start=%b idx=%0d busy=%b done=%b err=%b fd=%0d,",
                         cyc, rev_start, file_index, busy, done, error, files_done,
                         " expected start=%b idx=%0d busy=%b done=%b err=%b fd=%0d",
                         e_start, e_idx, e_busy, e_done, e_err, e_fd);
            end
            if (rev_start) begin
                log_idx.push_back(int'(file_index));
                log_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (rev_finish) last_fin_cyc = cyc;
            if (error && !prev_err) err_rise_cyc = cyc;
            prev_err = error;

            if (rst_n) begin
                n_start = 0; n_done = 0;
                n_busy = e_busy; n_err = e_err; n_fd = e_fd; n_idx = e_idx;
                // A go is honoured only if the scheduler is idle in the following cycle.
                if (go && !m_engaged && cyc >= m_done_cyc) begin
                    m_engaged   = 1;
                    m_cur       = first_idx;
                    m_last      = last_idx;
                    m_launch_at = cyc + 2;
                end
                if (m_launch_at == cyc + 1) begin
                    n_start = 1; n_idx = m_cur; n_busy = 1; n_fd = '0; n_err = 0;
                    m_running = 1; m_start_cyc = cyc + 1;
                end
                if (m_running && cyc > m_start_cyc) begin
                    if (rev_finish) begin
                        n_fd = e_fd + 1;
                        m_running = 0;
                        m_decide_at = cyc + 1;
                    end else if (cyc - m_start_cyc == TMO - 1) begin
                        n_err = 1; n_done = 1; n_busy = 0;
                        m_running = 0; m_engaged = 0; m_done_cyc = cyc + 1;
                    end
                end else if (m_decide_at == cyc) begin
                    if (m_cur == m_last || abort) begin
                        n_done = 1; n_busy = 0;
                        m_engaged = 0; m_done_cyc = cyc + 1;
                    end else begin
                        m_cur = m_cur + 1'b1;
                        n_start = 1; n_idx = m_cur;
                        m_running = 1; m_start_cyc = cyc + 1;
                    end
                end
                e_start = n_start; e_busy = n_busy; e_done = n_done;
                e_err = n_err; e_idx = n_idx; e_fd = n_fd;
            end
        end
    end

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, " done pulses"}, done_cnt - base, 1);
    endtask

    task automatic run_batch(input int f, input int l, input int lat, input bit ab,
                             input string name);
        int base;
        rv_lat = lat;
        log_idx.delete();
        log_cyc.delete();
        base = done_cnt;
        @(posedge clk);
        #1;
        first_idx = FW'(f);
        last_idx  = FW'(l);
        go        = 1'b1;
        abort     = ab;
        go_cyc    = cyc;
        @(posedge clk);
        #1;
        go = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done(base, name);
    endtask

    task automatic check_seq(input string name);
        chk({name, " start count"}, log_idx.size(), exp_seq.size());
        foreach (exp_seq[i]) begin
            if (i < log_idx.size()) begin
                chk($sformatf("%s start %0d index", name, i), log_idx[i], exp_seq[i]);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global time limit reached: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; first_idx = '0; last_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset files_done", files_done, 0);
        chk("reset busy", busy, 0);

        // Stray finish while idle changes nothing.
        @(negedge clk);
        stray_fin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle stray files_done", files_done, 0);

        // 1: three files 5..7
        run_batch(5, 7, 10, 1'b0, "t1");
        exp_seq = '{5, 6, 7};
        check_seq("t1");
        if (log_cyc.size() >= 2) begin
            chk("t1 go->start", log_cyc[0] - go_cyc, 2);
            chk("t1 start->start", log_cyc[1] - log_cyc[0], 12);
        end
        chk("t1 finish->done", last_done_cyc - last_fin_cyc, 2);
        chk("t1 files_done", files_done, 3);
        chk("t1 error", error, 0);
        @(negedge clk);
        stray_fin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t1 stray keeps files_done", files_done, 3);

        // 2: single file
        run_batch(0, 0, 10, 1'b0, "t2");
        exp_seq = '{0};
        check_seq("t2");
        chk("t2 finish->done", last_done_cyc - last_fin_cyc, 2);
        chk("t2 busy after", busy, 0);
        chk("t2 files_done", files_done, 1);

        // 3: wrapping range; abort held only while idle is ignored
        run_batch(1022, 1, 10, 1'b1, "t3");
        exp_seq = '{1022, 1023, 0, 1};
        check_seq("t3");
        chk("t3 files_done", files_done, 4);

        // 4: never finishes -> timeout, then next go clears error
        run_batch(9, 9, 0, 1'b0, "t4");
        exp_seq = '{9};
        check_seq("t4");
        if (log_cyc.size() >= 1) chk("t4 start->error", err_rise_cyc - log_cyc[0], 16);
        chk("t4 error", error, 1);
        chk("t4 files_done", files_done, 0);
        run_batch(3, 3, 10, 1'b0, "t4b");
        chk("t4b error cleared", error, 0);
        chk("t4b files_done", files_done, 1);
        // Finish in the expiry cycle wins; one cycle later is a timeout.
        run_batch(4, 4, 15, 1'b0, "t4c");
        chk("t4c error", error, 0);
        chk("t4c files_done", files_done, 1);
        run_batch(4, 4, 16, 1'b0, "t4d");
        chk("t4d error", error, 1);
        chk("t4d files_done", files_done, 0);

        // 5: abort during the third file of 5..9
        rv_lat = 10;
        log_idx.delete();
        log_cyc.delete();
        base = done_cnt;
        @(posedge clk);
        #1;
        first_idx = 10'd5; last_idx = 10'd9; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        n = 0;
        while (log_idx.size() < 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        abort = 1'b1;
        wait_done(base, "t5");
        abort = 1'b0;
        exp_seq = '{5, 6, 7};
        check_seq("t5");
        chk("t5 files_done", files_done, 3);

        // 6: reset mid-WAIT, late finish ignored, then go while busy ignored
        log_idx.delete();
        log_cyc.delete();
        @(posedge clk);
        #1;
        first_idx = 10'd100; last_idx = 10'd105; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        n = 0;
        while (log_idx.size() < 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t6 files_done before reset", files_done, 1);
        rst_n = 1'b0;
        #1;
        chk("t6 outputs in reset", {rev_start, file_index, busy, done, error, files_done}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("t6 late finish files_done", files_done, 0);
        chk("t6 late finish busy", busy, 0);

        log_idx.delete();
        log_cyc.delete();
        base = done_cnt;
        @(posedge clk);
        #1;
        first_idx = 10'd2; last_idx = 10'd3; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        n = 0;
        while (log_idx.size() < 1 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        first_idx = 10'd50; last_idx = 10'd60; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        wait_done(base, "t6b");
        exp_seq = '{2, 3};
        check_seq("t6b");
        chk("t6b files_done", files_done, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
